cp0_unit: RTL and testbench

- Parametrised next-generation coprocessor-0 for the 5-stage MIPS core; sits beside the M stage.
- Holds SR, Cause, EPC, PRId, plus a Count/Compare timer.
- Arbitrates interrupt and exception requests and raises `req` to flush the pipeline and redirect to the handler.
- Adds three things: a configurable number of hardware interrupt lines, per-line level or edge capture, and correct delay-slot EPC rewind (EPC = PC-4 plus Cause.BD).

---
 rtl/cp0_defs.sv | 25 ++
 rtl/cp0_unit_timer.sv | 38 +++
 rtl/cp0_unit.sv | 135 +++++++++++++
 tb/tb_cp0_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_defs.sv
// Shared CP0 definitions: register indices, exception codes and SR/Cause field positions.
package cp0_defs;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int unsigned SR_IE       = 0;
    localparam int unsigned SR_EXL      = 1;
    localparam int unsigned SR_IM_LO    = 10;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_IP_LO = 10;
    localparam int unsigned CAUSE_BD    = 31;
    localparam int unsigned IP_TIMER    = 5;

endpackage

// File: rtl/cp0_unit_timer.sv
// Count/Compare timer: free-running counter, compare register and sticky match flag.
module cp0_timer
    import cp0_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        pending
);

    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        pending_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            pending_q <= 1'b0;
        end else begin
            count_q <= we_count ? wdata : count_q + 32'd1;
            if (we_compare) begin
                compare_q <= wdata;
            end
            // A Compare write acknowledges the interrupt, even against a same-cycle match.
            pending_q <= we_compare ? 1'b0 : (pending_q | (count_q == compare_q));
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign pending = pending_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: status/cause/EPC state, interrupt capture, timer and exception request logic.
module cp0_unit
    import cp0_defs::*;
#(
    parameter int unsigned NUM_HWINT = 6,
    parameter logic [5:0]  EDGE_MASK = 6'b000000,
    parameter bit          TIMER_EN  = 1'b1,
    parameter logic [31:0] PRID_VAL  = 32'h0000_0501
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [4:0]           wr_addr,
    input  logic [31:0]          wdata,
    input  logic [4:0]           rd_addr,
    output logic [31:0]          rdata,
    input  logic [31:0]          vpc,
    input  logic                 is_bd,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_code,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 eret,
    output logic                 req,
    output logic [31:0]          epc_out
);

    localparam logic [NUM_HWINT-1:0] EMASK = EDGE_MASK[NUM_HWINT-1:0];

    logic [NUM_HWINT-1:0] hw_q;
    logic [NUM_HWINT-1:0] pend_q;
    logic [5:0]           im_q;
    logic                 exl_q;
    logic                 ie_q;
    logic                 bd_q;
    logic [4:0]           code_q;
    logic [31:0]          epc_q;

    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_pend;

    logic [5:0]           ip;
    logic                 int_req;
    logic                 exc_req;
    logic                 take;
    logic                 wr;
    logic [NUM_HWINT-1:0] pend_set;
    logic [NUM_HWINT-1:0] pend_clr;

    always_comb begin
        ip = '0;
        for (int unsigned i = 0; i < NUM_HWINT; i++) begin
            ip[i] = EMASK[i] ? pend_q[i] : hw_q[i];
        end
        ip[IP_TIMER] = ip[IP_TIMER] | timer_pend;
    end

    assign int_req = (|(ip & im_q)) & ie_q & ~exl_q;
    assign exc_req = exc_valid & ~exl_q;
    assign req     = int_req | exc_req;

    // eret outranks a coincident request; mtc0 only lands when neither is active.
    assign take = req & ~eret;
    assign wr   = we & ~req & ~eret;

    assign pend_set = hw_int & ~hw_q & EMASK;
    assign pend_clr = (wr && wr_addr == CP0_CAUSE) ?
                      (~wdata[CAUSE_IP_LO +: NUM_HWINT] & EMASK) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            hw_q   <= '0;
            pend_q <= '0;
            im_q   <= '0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            code_q <= '0;
            epc_q  <= '0;
        end else begin
            hw_q   <= hw_int;
            pend_q <= (pend_q & ~pend_clr) | pend_set;
            if (eret) begin
                exl_q <= 1'b0;
            end else if (take) begin
                exl_q  <= 1'b1;
                code_q <= int_req ? EXC_INT : exc_code;
                bd_q   <= is_bd;
                epc_q  <= is_bd ? vpc - 32'd4 : vpc;
            end else if (wr) begin
                if (wr_addr == CP0_SR) begin
                    im_q  <= wdata[SR_IM_LO +: 6];
                    exl_q <= wdata[SR_EXL];
                    ie_q  <= wdata[SR_IE];
                end
                if (wr_addr == CP0_EPC) begin
                    epc_q <= wdata;
                end
            end
        end
    end

    if (TIMER_EN) begin : g_timer
        cp0_timer u_timer (
            .clk        (clk),
            .reset      (reset),
            .we_count   (wr && wr_addr == CP0_COUNT),
            .we_compare (wr && wr_addr == CP0_COMPARE),
            .wdata      (wdata),
            .count      (count),
            .compare    (compare),
            .pending    (timer_pend)
        );
    end else begin : g_no_timer
        assign count      = '0;
        assign compare    = '0;
        assign timer_pend = 1'b0;
    end

    always_comb begin
        rdata = '0;
        case (rd_addr)
            CP0_COUNT:   rdata = count;
            CP0_COMPARE: rdata = compare;
            CP0_SR:      rdata = {16'b0, im_q, 8'b0, exl_q, ie_q};
            CP0_CAUSE:   rdata = {bd_q, 15'b0, ip, 3'b0, code_q, 2'b0};
            CP0_EPC:     rdata = epc_q;
            CP0_PRID:    rdata = PRID_VAL;
            default:     rdata = '0;
        endcase
    end

    assign epc_out = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed plus randomized bench for cp0_unit, checked against a register-level behavioural model.
module tb_cp0_unit;

    localparam logic [5:0] EMASK = 6'b000010;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rdata;
    logic [31:0] vpc;
    logic        is_bd;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    int vectors = 0;
    int fails   = 0;

    cp0_unit #(
        .NUM_HWINT (6),
        .EDGE_MASK (EMASK),
        .TIMER_EN  (1'b1),
        .PRID_VAL  (32'h0000_0501)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .wr_addr   (wr_addr),
        .wdata     (wdata),
        .rd_addr   (rd_addr),
        .rdata     (rdata),
        .vpc       (vpc),
        .is_bd     (is_bd),
        .exc_valid (exc_valid),
        .exc_code  (exc_code),
        .hw_int    (hw_int),
        .eret      (eret),
        .req       (req),
        .epc_out   (epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, in architectural terms.
    logic        m_ie, m_exl, m_bd, m_tp;
    logic [5:0]  m_im, m_hwq, m_pend;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_count, m_cmp;

    function automatic logic [5:0] m_ip();
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = EMASK[i] ? m_pend[i] : m_hwq[i];
        r[5] = r[5] | m_tp;
        return r;
    endfunction

    function automatic logic m_int();
        return (|(m_ip() & m_im)) && m_ie && !m_exl;
    endfunction

    function automatic logic m_req();
        return m_int() || (exc_valid && !m_exl);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_cmp;
            5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13:   return (32'(m_bd) << 31) | (32'(m_ip()) << 10) | (32'(m_code) << 2);
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_0501;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_update();
        logic        r, it, take, wrt;
        logic [5:0]  clr;
        r    = m_req();
        it   = m_int();
        take = r && !eret;
        wrt  = we && !r && !eret;
        if (reset) begin
            m_ie = 0; m_exl = 0; m_bd = 0; m_tp = 0; m_im = 0; m_hwq = 0; m_pend = 0;
            m_code = 0; m_epc = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
            return;
        end
        clr = (wrt && wr_addr == 5'd13) ? (~wdata[15:10] & EMASK) : 6'b0;
        m_pend = (m_pend & ~clr) | (hw_int & ~m_hwq & EMASK);
        m_hwq  = hw_int;
        if (wrt && wr_addr == 5'd11) m_tp = 0;
        else if (m_count == m_cmp) m_tp = 1;
        m_count = (wrt && wr_addr == 5'd9) ? wdata : m_count + 1;
        if (wrt && wr_addr == 5'd11) m_cmp = wdata;
        if (eret) m_exl = 0;
        else if (take) begin
            m_exl = 1;
            m_code = it ? 5'd0 : exc_code;
            m_bd = is_bd;
            m_epc = is_bd ? vpc - 4 : vpc;
        end else if (wrt) begin
            if (wr_addr == 5'd12) begin
                m_im = wdata[15:10]; m_exl = wdata[1]; m_ie = wdata[0];
            end
            if (wr_addr == 5'd14) m_epc = wdata;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check outputs mid-cycle against the model, then clock the DUT and the model together.
    task automatic step();
        @(negedge clk);
        chk("req", {31'b0, req}, {31'b0, m_req()});
        chk("rdata", rdata, m_read(rd_addr));
        chk("epc_out", epc_out, m_epc);
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        rd_addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1; wr_addr = a; wdata = d;
        step();
        we = 0;
    endtask

    logic [4:0] addrs [7];
    int n;

    initial begin
        addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        reset = 1; we = 0; wr_addr = 0; wdata = 0; rd_addr = 0; vpc = 0; is_bd = 0;
        exc_valid = 0; exc_code = 0; hw_int = 0; eret = 0;
        @(posedge clk); m_update(); #1;
        step();
        reset = 0;

        rd_chk("rst_sr", 5'd12, 32'h0);
        rd_chk("rst_cause", 5'd13, 32'h0);
        rd_chk("rst_epc", 5'd14, 32'h0);
        rd_chk("rst_compare", 5'd11, 32'hFFFF_FFFF);
        rd_chk("rst_prid", 5'd15, 32'h0000_0501);
        rd_chk("rst_unused", 5'd3, 32'h0);
        chk("rst_req", {31'b0, req}, 32'h0);

        // Level interrupt on line 0.
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        step();
        hw_int = 0;
        #1 chk("lvl_req", {31'b0, req}, 32'h1);
        step();
        chk("lvl_req_off", {31'b0, req}, 32'h0);
        rd_chk("lvl_cause", 5'd13, 32'h0);
        rd_chk("lvl_sr_exl", 5'd12, 32'h0000_0403);
        eret = 1; step(); eret = 0;
        rd_chk("eret_sr", 5'd12, 32'h0000_0401);

        // Edge-captured line 1, masked.
        hw_int = 6'b000010;
        step();
        hw_int = 0;
        step();
        rd_chk("edge_ip", 5'd13, 32'h0000_0800);
        step();
        rd_chk("edge_sticky", 5'd13, 32'h0000_0800);
        mtc0(5'd13, 32'h0000_0800);
        rd_chk("edge_w1_noeff", 5'd13, 32'h0000_0800);
        mtc0(5'd13, 32'h0);
        rd_chk("edge_clr", 5'd13, 32'h0);

        // Exceptions with and without delay slot.
        mtc0(5'd12, 32'h0);
        exc_valid = 1; exc_code = 5'd12; vpc = 32'h3008; is_bd = 1;
        #1 chk("exc_req", {31'b0, req}, 32'h1);
        step();
        exc_valid = 0;
        rd_chk("bd_epc", 5'd14, 32'h3004);
        rd_chk("bd_cause", 5'd13, 32'h8000_0030);
        rd_chk("bd_sr", 5'd12, 32'h2);
        eret = 1; step(); eret = 0;
        exc_valid = 1; is_bd = 0;
        step();
        exc_valid = 0;
        rd_chk("nbd_epc", 5'd14, 32'h3008);
        rd_chk("nbd_cause", 5'd13, 32'h30);
        eret = 1; step(); eret = 0;

        // Interrupt beats a coincident exception and a coincident mtc0.
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        step();
        hw_int = 0;
        exc_valid = 1; exc_code = 5'd10; vpc = 32'h4000;
        we = 1; wr_addr = 5'd14; wdata = 32'hDEAD_0000;
        step();
        exc_valid = 0; we = 0;
        rd_chk("prio_epc", 5'd14, 32'h4000);
        rd_chk("prio_cause", 5'd13, 32'h0);
        eret = 1; step(); eret = 0;

        // Timer.
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        n = 0;
        while (!req && n < 12) begin
            step();
            n++;
        end
        chk("timer_latency", 32'(n >= 6 && n <= 7), 32'h1);
        rd_chk("timer_ip", 5'd13, 32'h0000_8000);
        step();
        mtc0(5'd11, 32'hFFFF_0000);
        rd_chk("timer_clr", 5'd13, 32'h0);
        eret = 1; step(); eret = 0;
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd_chk("count_max", 5'd9, 32'hFFFF_FFFF);
        step();
        rd_chk("count_wrap", 5'd9, 32'h0);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            reset     = ($urandom_range(0, 99) < 2);
            we        = ($urandom_range(0, 3) == 0);
            wr_addr   = addrs[$urandom_range(0, 6)];
            wdata     = $urandom;
            if (wr_addr == 5'd9) wdata = m_cmp - 32'($urandom_range(0, 5));
            rd_addr   = addrs[$urandom_range(0, 6)];
            exc_valid = ($urandom_range(0, 9) == 0);
            exc_code  = 5'($urandom);
            vpc       = $urandom & 32'hFFFF_FFFC;
            is_bd     = 1'($urandom);
            eret      = ($urandom_range(0, 5) == 0);
            for (int b = 0; b < 6; b++)
                if ($urandom_range(0, 7) == 0) hw_int[b] = ~hw_int[b];
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
